// File: rtl/prra_mux_if.sv
// prra_mux_if: requester streams, arbiter request/grant and output stream of prra_mux
interface prra_mux_if #(
  parameter int WIDTH = 4,
  parameter int LOG2_WIDTH = 2,
  parameter int DATA_WIDTH = 32
);
  logic [WIDTH-1:0] in_valid, in_ready, in_last, request, grant;
  logic [WIDTH*DATA_WIDTH-1:0] in_data;
  logic out_valid, out_ready, out_last, busy, error;
  logic [DATA_WIDTH-1:0] out_data;
  logic [LOG2_WIDTH-1:0] out_port;
  modport master (
    output in_valid, in_data, in_last, grant, out_ready,
    input in_ready, request, out_valid, out_data, out_last, out_port, busy, error
  );
  modport slave (
    input in_valid, in_data, in_last, grant, out_ready,
    output in_ready, request, out_valid, out_data, out_last, out_port, busy, error
  );
endinterface

// File: rtl/prra_mux.sv
// prra_mux: locks onto the granted requester until its last beat and forwards it through a registered output.
// Defining PRRA_MUX_CHECK_EN builds the grant protocol checker driving error.
module prra_mux #(
  parameter int WIDTH = 4,
  parameter int LOG2_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int GRANT_LATENCY = 0
) (
  input logic clk,
  input logic arst,
  prra_mux_if.slave bus
);
  localparam int CW = GRANT_LATENCY > 0 ? $clog2(GRANT_LATENCY + 1) : 1;
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sel, gnt_low;
  logic [LOG2_WIDTH-1:0] idx, gnt_idx;
  logic [CW-1:0] cnt;
  logic take, open, accept;
  assign gnt_low = bus.grant & (~bus.grant + 1'b1);
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (gnt_low[i]) gnt_idx = LOG2_WIDTH'(i);
  end
  // the output register may refill in the same cycle it drains
  assign open = state == XFER && (!bus.out_valid || bus.out_ready);
  assign accept = open && bus.in_valid[idx];
  assign bus.in_ready = open ? sel : '0;
  assign bus.request = (state == IDLE && !arst) ? bus.in_valid : '0;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_n = state;
    if (state == IDLE && take) state_n = XFER;
    else if (state == XFER && accept && bus.in_last[idx]) state_n = GRANT_LATENCY > 0 ? DRAIN : IDLE;
    else if (state == DRAIN && cnt == CW'(1)) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge arst)
    if (arst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      sel <= '0;
      idx <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && take) begin
        sel <= gnt_low;
        idx <= gnt_idx;
      end
      if (state == XFER && state_n == DRAIN) cnt <= CW'(GRANT_LATENCY);
      else if (state == DRAIN) cnt <= cnt - 1'b1;
    end
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_last <= 1'b0;
      bus.out_port <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data <= bus.in_data[idx*DATA_WIDTH +: DATA_WIDTH];
      bus.out_last <= bus.in_last[idx];
      bus.out_port <= idx;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_last <= 1'b0;
      bus.out_port <= '0;
    end
`ifdef PRRA_MUX_CHECK_EN
  logic [WIDTH-1:0] req_old;
  // a legal grant answers the request presented GRANT_LATENCY cycles earlier
  if (GRANT_LATENCY == 0) begin : g_hist0
    assign req_old = bus.request;
  end else begin : g_hist
    logic [WIDTH-1:0] hist [GRANT_LATENCY];
    always_ff @(posedge clk or posedge arst)
      if (arst) for (int i = 0; i < GRANT_LATENCY; i++) hist[i] <= '0;
      else begin
        hist[0] <= bus.request;
        for (int i = 1; i < GRANT_LATENCY; i++) hist[i] <= hist[i-1];
      end
    assign req_old = hist[GRANT_LATENCY-1];
  end
  assign take = bus.grant != '0 && (bus.grant & (bus.grant - 1'b1)) == '0;
  always_ff @(posedge clk or posedge arst)
    if (arst) bus.error <= 1'b0;
    else if (state == IDLE && bus.grant != '0 && (!take || |(bus.grant & ~req_old))) bus.error <= 1'b1;
`else
  assign take = |bus.grant;
  assign bus.error = 1'b0;
`endif
endmodule
